// File: rtl/irq_controller.sv
// Prioritised interrupt source for the pipelined core: latches requests, issues one pulse at a time,
// waits for EOI and a hold-off gap. Define IRQ_EDGE_DETECT_EN for rising-edge capture (default is level).
module irq_controller #(
   parameter int NUM_IRQ = 4,
   parameter int HOLDOFF = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic               i_mask_wr,
   input  logic [NUM_IRQ-1:0] i_mask_data,
   input  logic               i_eoi,
   output logic               o_interrupt,
   output logic [15:0]        o_irq_id,
   output logic [NUM_IRQ-1:0] o_pending,
   output logic               o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_SERVICE,
      ST_HOLDOFF
   } state_e;

   localparam logic [7:0] HOLD_INIT = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

   state_e             state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [3:0]         id_q, id_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               interrupt_q, interrupt_d;

   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] setVec;
   logic [NUM_IRQ-1:0] clearVec;
   logic [3:0]         winnerIdx;
   logic               start;

`ifdef IRQ_EDGE_DETECT_EN
   logic [NUM_IRQ-1:0] hist_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hist_q <= '0;
      end else begin
         hist_q <= i_irq;
      end
   end

   always_comb begin
      setVec = i_irq & ~hist_q;
   end
`else
   always_comb begin
      setVec = i_irq;
   end
`endif

   // Scanning from the top down lets the lowest eligible index overwrite the result last.
   always_comb begin
      eligible  = pending_q & ~mask_q;
      winnerIdx = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            winnerIdx = 4'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      interrupt_d = 1'b0;
      start       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               start       = 1'b1;
               state_d     = ST_PULSE;
               id_d        = winnerIdx;
               interrupt_d = 1'b1;
            end
         end
         ST_PULSE: begin
            state_d = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (i_eoi) begin
               if (HOLDOFF == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLDOFF;
                  cnt_d   = HOLD_INIT;
               end
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A request arriving on the same edge its bit is cleared must survive, so set is applied last.
   always_comb begin
      for (int k = 0; k < NUM_IRQ; k++) begin
         clearVec[k] = start && (winnerIdx == 4'(k));
      end
      pending_d = (pending_q & ~clearVec) | setVec;
      mask_d    = i_mask_wr ? i_mask_data : mask_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         mask_q      <= '1;
         id_q        <= '0;
         cnt_q       <= '0;
         interrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         interrupt_q <= interrupt_d;
      end
   end

   always_comb begin
      o_interrupt = interrupt_q;
      o_pending   = pending_q;
      o_busy      = (state_q != ST_IDLE);
      o_irq_id    = '0;
      if ((state_q == ST_PULSE) || (state_q == ST_SERVICE)) begin
         o_irq_id = {1'b1, 11'b0, id_q};
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a cycle-numbered reference model predicts pulses and per-cycle outputs,
// and a negedge monitor compares them against the DUT. Mode follows IRQ_EDGE_DETECT_EN like the design.
module tb_irq_controller;

   localparam int NUM_IRQ = 4;
   localparam int HOLDOFF = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq;
   logic        maskWr;
   logic [3:0]  maskData;
   logic        eoi;
   logic        interruptOut;
   logic [15:0] irqId;
   logic [3:0]  pendingOut;
   logic        busyOut;

   always #5 clk = ~clk;

   irq_controller #(
      .NUM_IRQ(NUM_IRQ),
      .HOLDOFF(HOLDOFF)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_irq       (irq),
      .i_mask_wr   (maskWr),
      .i_mask_data (maskData),
      .i_eoi       (eoi),
      .o_interrupt (interruptOut),
      .o_irq_id    (irqId),
      .o_pending   (pendingOut),
      .o_busy      (busyOut)
   );

   typedef struct {
      int id;
      int edgeNo;
   } pulse_t;

   typedef struct {
      logic [3:0]  pend;
      logic        busy;
      logic [15:0] irqId;
      logic        intr;
      int          edgeNo;
   } snap_t;

   pulse_t pulseQ[$];
   snap_t  snapQ[$];

   int checks   = 0;
   int failures = 0;

   // Model state is kept as cycle numbers: which request is in service, when it pulsed,
   // and the first cycle in which the controller is free again.
   logic [3:0] mPend;
   logic [3:0] mMask;
   logic [3:0] mHist;
   int         mCurId;
   int         mPulseEdge;
   int         mIdleFrom;
   int         edgeNum = 0;

   task automatic checkOutput(input string name, input int edgeNo, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edgeNo, act, exp);
      end
   endtask

   task automatic modelStep(input logic r, input logic [3:0] irqV, input logic mw,
                            input logic [3:0] md, input logic e);
      snap_t      s;
      logic [3:0] elig;
      bit         idle;
      int         w;
      edgeNum++;
      if (r) begin
         mPend      = '0;
         mMask      = '1;
         mHist      = '0;
         mCurId     = -1;
         mPulseEdge = -100;
         mIdleFrom  = edgeNum;
      end else begin
         idle = (mCurId < 0) && (edgeNum - 1 >= mIdleFrom);
         elig = mPend & ~mMask;
         w    = -1;
         for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (((elig >> k) & 4'd1) != 4'd0) w = k;
         end
         if (idle && w >= 0) begin
            mPend      = mPend & ~(4'd1 << w);
            mCurId     = w;
            mPulseEdge = edgeNum;
            pulseQ.push_back('{w, edgeNum});
         end else if (mCurId >= 0 && edgeNum - 1 > mPulseEdge && e) begin
            mCurId    = -1;
            mIdleFrom = edgeNum + HOLDOFF;
         end
`ifdef IRQ_EDGE_DETECT_EN
         mPend = mPend | (irqV & ~mHist);
`else
         mPend = mPend | irqV;
`endif
         if (mw) mMask = md;
         mHist = irqV;
      end
      s.pend   = mPend;
      s.busy   = !((mCurId < 0) && (edgeNum >= mIdleFrom));
      s.irqId  = (mCurId >= 0) ? (16'h8000 | 16'(mCurId)) : 16'h0000;
      s.intr   = (mPulseEdge == edgeNum);
      s.edgeNo = edgeNum;
      snapQ.push_back(s);
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] irqV, input logic mw,
                                input logic [3:0] md, input logic e);
      reset    = r;
      irq      = irqV;
      maskWr   = mw;
      maskData = md;
      eoi      = e;
      @(posedge clk);
      modelStep(r, irqV, mw, md, e);
      #2;
   endtask

   task automatic runIdle(input int n);
      repeat (n) applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
   endtask

   snap_t  monSnap;
   pulse_t monPulse;

   // Monitor: one snapshot per cycle, and one scoreboard entry consumed per observed pulse.
   always @(negedge clk) begin
      if (snapQ.size() > 0) begin
         monSnap = snapQ.pop_front();
         checkOutput("pending", monSnap.edgeNo, 16'(pendingOut), 16'(monSnap.pend));
         checkOutput("busy", monSnap.edgeNo, 16'(busyOut), 16'(monSnap.busy));
         checkOutput("irq_id", monSnap.edgeNo, irqId, monSnap.irqId);
         checkOutput("interrupt", monSnap.edgeNo, 16'(interruptOut), 16'(monSnap.intr));
         if (interruptOut === 1'b1) begin
            if (pulseQ.size() == 0) begin
               checkOutput("unexpected_pulse", monSnap.edgeNo, 16'd1, 16'd0);
            end else begin
               monPulse = pulseQ.pop_front();
               checkOutput("pulse_edge", monSnap.edgeNo, 16'(monSnap.edgeNo), 16'(monPulse.edgeNo));
               checkOutput("pulse_id", monSnap.edgeNo, irqId, 16'h8000 | 16'(monPulse.id));
            end
         end
      end
   end

   initial begin
      logic       r;
      logic [3:0] irqV;
      logic       mw;
      logic [3:0] md;
      logic       e;

      $display("[TB] irq_controller scoreboard bench starting");
      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // Single request on line 2.
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0);
      runIdle(3);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(8);

      // Two simultaneous requests: lowest index first.
      applyStimulus(1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0);
      runIdle(3);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(6);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(8);

      // Masked request latches but does not fire until unmasked.
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      runIdle(3);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      runIdle(3);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(8);

      // Line 1 held high for 40 cycles with periodic EOIs.
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0000, (i % 3) == 2);
      end
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(3);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(8);

      // Spurious EOIs while idle.
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(2);

      // Reset in the middle of servicing; mask returns to all ones.
      applyStimulus(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
      runIdle(3);
      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0);
      runIdle(4);
      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0);

      // New rising edge on line 0 exactly when its pending bit is consumed.
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
      runIdle(2);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(6);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
      runIdle(8);

      // Randomised traffic with occasional resets and mask rewrites.
      for (int i = 0; i < 2000; i++) begin
         r    = ($urandom_range(0, 299) == 0);
         irqV = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         mw   = ($urandom_range(0, 19) == 0);
         md   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         e    = ($urandom_range(0, 2) == 0);
         applyStimulus(r, irqV, mw, md, e);
      end
      runIdle(2);

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", edgeNum, 16'(pulseQ.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
